// File: rtl/alu_op_scheduler_pkg.sv
// alu_sched_pkg: op codes, datapath select encodings and pipeline stage type for the ALU scheduler
package alu_sched_pkg;
    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_ADD = 2'b01,
        OP_DIV = 2'b10,
        OP_SUB = 2'b11
    } op_t;
    localparam logic [3:0] SEL_MUL = 4'b1000;
    localparam logic [3:0] SEL_ADD = 4'b0100;
    localparam logic [3:0] SEL_DIV = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0001;
    localparam int ID_MAX_W = 8;
    typedef struct packed {
        logic                v;
        logic [ID_MAX_W-1:0] id;
        op_t                 op;
        logic                dz;
    } stage_t;
    function automatic logic [3:0] sel_of(op_t op);
        return op == OP_MUL ? SEL_MUL : op == OP_ADD ? SEL_ADD : op == OP_DIV ? SEL_DIV : SEL_SUB;
    endfunction
endpackage

// File: rtl/alu_op_scheduler_if.sv
// alu_op_scheduler_if: requester-side request/grant/response bundle of the ALU scheduler
interface alu_op_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] req_op;
    logic [4*N_REQ-1:0] req_a;
    logic [4*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]   gnt;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [7:0]         rsp_data;
    logic               rsp_err;
    modport master (
        output req, req_op, req_a, req_b,
        input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err
    );
    modport slave (
        input  req, req_op, req_a, req_b,
        output gnt, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, highest priority at index ptr
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);
    localparam int ID_W = $clog2(N_REQ);
    logic [ID_W-1:0] j;
    // scan from lowest priority to highest so the last hit is the winner
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        any = 1'b0;
        j = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = ID_W'((int'(ptr) + k) % N_REQ);
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                gnt_idx = j;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: round-robin front end sharing one 2-cycle ALU datapath among requesters
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_scheduler_if.slave bus,
    output logic [3:0]        dp_a,
    output logic [3:0]        dp_b,
    output logic [3:0]        dp_sel,
    input  logic [7:0]        dp_out,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);
    localparam int ID_W = $clog2(N_REQ);
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [N_REQ-1:0] arb_gnt;
    logic             any;
    logic [3:0]       a_arr [N_REQ];
    logic [3:0]       b_arr [N_REQ];
    op_t              op_arr [N_REQ];
    logic [3:0]       g_a;
    logic [3:0]       g_b;
    op_t              g_op;
    stage_t           s1;
    stage_t           s2;
    stage_t           s3;
    logic             unused_bits;
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[4*i +: 4];
        assign b_arr[i] = bus.req_b[4*i +: 4];
        assign op_arr[i] = op_t'(bus.req_op[2*i +: 2]);
    end
    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req(bus.req),
        .ptr(ptr),
        .gnt(arb_gnt),
        .gnt_idx(gnt_idx),
        .any(any)
    );
    assign g_a = a_arr[gnt_idx];
    assign g_b = b_arr[gnt_idx];
    assign g_op = op_arr[gnt_idx];
    assign bus.gnt = rst ? arb_gnt : '0;
    assign busy = s1.v | s2.v | s3.v;
    assign unused_bits = ^{s3.op, s3.id};
    // accept the granted payload; operands only move on a grant so the datapath stays quiet when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            dp_a <= '0;
            dp_b <= '0;
            s1 <= '0;
        end else begin
            if (any) begin
                ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                dp_a <= g_a;
                dp_b <= g_b;
            end
            s1 <= '{v: any, id: ID_MAX_W'(gnt_idx), op: g_op, dz: any && g_op == OP_DIV && g_b == 4'd0};
        end
    end
    // select trails the operands by one cycle to match the datapath's internal operand register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dp_sel <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            dp_sel <= s1.v ? sel_of(s1.op) : 4'b0000;
            s2 <= s1;
            s3 <= s2;
        end
    end
    // capture the datapath result for the op leaving S3 and count completions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= '0;
            bus.rsp_data <= '0;
            bus.rsp_err <= 1'b0;
            done_cnt <= '0;
        end else begin
            bus.rsp_valid <= s3.v;
            if (s3.v) begin
                bus.rsp_id <= s3.id[ID_W-1:0];
                bus.rsp_err <= s3.dz;
                bus.rsp_data <= s3.dz ? 8'h00 : dp_out;
            end
            done_cnt <= (s3.v && !(&done_cnt)) ? done_cnt + 1'b1 : done_cnt;
        end
    end
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: table vectors, corner sequences and random traffic against a scoreboard model
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;
    localparam int N = 4;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;
    typedef struct {
        int         due;
        int         id;
        logic [1:0] op;
        logic [7:0] data;
        logic       err;
    } ent_t;
    typedef struct {
        int         id;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] data;
        logic       err;
        logic [3:0] sel;
    } vec_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    dp_a, dp_b, dp_sel;
    logic [7:0]    dp_out = 8'h00;
    logic          busy;
    logic [CW-1:0] done_cnt;
    logic [3:0]    a_r = 4'h0;
    logic [3:0]    b_r = 4'h0;
    alu_op_scheduler_if #(.N_REQ(N)) bus ();
    alu_op_scheduler #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_out(dp_out),
        .busy(busy), .done_cnt(done_cnt)
    );
    always #5 clk = ~clk;
    function automatic logic [7:0] dp_fn(logic [3:0] sel, logic [3:0] a, logic [3:0] b);
        case (sel)
            4'b1000: return 8'(a) * 8'(b);
            4'b0100: return 8'(a) + 8'(b);
            4'b0010: return (b == 4'd0) ? 8'hFF : 8'(a) / 8'(b);
            4'b0001: return 8'(a) - 8'(b);
            default: return 8'hA5;
        endcase
    endfunction
    // shared datapath: operands registered internally, select one cycle later, result registered
    always @(posedge clk) begin
        a_r <= dp_a;
        b_r <= dp_b;
        if (dp_sel != 4'b0000) dp_out <= dp_fn(dp_sel, a_r, b_r);
    end
    logic       r_req [N];
    logic [1:0] r_op [N];
    logic [3:0] r_a [N];
    logic [3:0] r_b [N];
    ent_t       q[$];
    int         cyc = 0, ptr_m = 0, tot = 0, last_id = 0, last_g = -1;
    logic [7:0] last_data = 8'h00;
    logic       last_err = 1'b0;
    logic [3:0] last_a = 4'h0, last_b = 4'h0;
    int         n_cmp = 0, n_bad = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic ent_t mk(int id, logic [1:0] op, logic [3:0] a, logic [3:0] b, int due);
        ent_t e;
        int ia, ib, x;
        ia = int'(a);
        ib = int'(b);
        x = op == 2'd0 ? ia * ib : op == 2'd1 ? ia + ib : op == 2'd3 ? ia - ib + 256 : (ib == 0 ? 0 : ia / ib);
        e.due = due;
        e.id = id;
        e.op = op;
        e.err = op == 2'd2 && ib == 0;
        e.data = e.err ? 8'h00 : 8'(x % 256);
        return e;
    endfunction
    function automatic logic [3:0] onehot(logic [1:0] op);
        return 4'b1000 >> op;
    endfunction
    task automatic drive();
        for (int j = 0; j < N; j++) begin
            bus.req[j] = r_req[j];
            bus.req_op[2*j +: 2] = r_op[j];
            bus.req_a[4*j +: 4] = r_a[j];
            bus.req_b[4*j +: 4] = r_b[j];
        end
    endtask
    task automatic set_req(int j, logic [1:0] op, logic [3:0] a, logic [3:0] b);
        r_req[j] = 1'b1;
        r_op[j] = op;
        r_a[j] = a;
        r_b[j] = b;
    endtask
    task automatic model_reset();
        q.delete();
        ptr_m = 0;
        tot = 0;
        last_id = 0;
        last_data = 8'h00;
        last_err = 1'b0;
        last_a = 4'h0;
        last_b = 4'h0;
    endtask
    task automatic cycle();
        int g;
        ent_t e;
        logic [3:0] sel_e;
        g = -1;
        drive();
        #1;
        for (int k = 0; k < N; k++) if (g < 0 && r_req[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        chk("gnt", 32'(bus.gnt), g < 0 ? 0 : (1 << g));
        if (g >= 0) begin
            q.push_back(mk(g, r_op[g], r_a[g], r_b[g], cyc + 4));
            last_a = r_a[g];
            last_b = r_b[g];
            ptr_m = (g + 1) % N;
            r_req[g] = 1'b0;
        end
        last_g = g;
        @(posedge clk);
        cyc++;
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            last_id = e.id;
            last_data = e.data;
            last_err = e.err;
            tot++;
            chk("rsp_valid", 32'(bus.rsp_valid), 1);
        end else begin
            chk("rsp_valid", 32'(bus.rsp_valid), 0);
        end
        sel_e = 4'b0000;
        foreach (q[i]) if (q[i].due == cyc + 2) sel_e = onehot(q[i].op);
        chk("rsp_id", 32'(bus.rsp_id), last_id);
        chk("rsp_data", 32'(bus.rsp_data), 32'(last_data));
        chk("rsp_err", 32'(bus.rsp_err), 32'(last_err));
        chk("done_cnt", 32'(done_cnt), tot > SAT ? SAT : tot);
        chk("busy", 32'(busy), q.size() > 0 ? 1 : 0);
        chk("dp_a", 32'(dp_a), 32'(last_a));
        chk("dp_b", 32'(dp_b), 32'(last_b));
        chk("dp_sel", 32'(dp_sel), 32'(sel_e));
    endtask
    task automatic apply_reset();
        for (int j = 0; j < N; j++) r_req[j] = 1'b0;
        drive();
        rst = 1'b0;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_dp_a", 32'(dp_a), 0);
        chk("rst_dp_b", 32'(dp_b), 0);
        chk("rst_dp_sel", 32'(dp_sel), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_cnt", 32'(done_cnt), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold_rsp_valid", 32'(bus.rsp_valid), 0);
        end
        rst = 1'b1;
        model_reset();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t tbl [8];
        int rr_exp [5];
        tbl[0] = '{0, OP_MUL, 4'd7,  4'd9,  8'h3F, 1'b0, 4'b1000};
        tbl[1] = '{1, OP_MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 4'b1000};
        tbl[2] = '{2, OP_SUB, 4'd3,  4'd5,  8'hFE, 1'b0, 4'b0001};
        tbl[3] = '{3, OP_ADD, 4'd15, 4'd15, 8'h1E, 1'b0, 4'b0100};
        tbl[4] = '{0, OP_DIV, 4'd9,  4'd2,  8'h04, 1'b0, 4'b0010};
        tbl[5] = '{1, OP_DIV, 4'd9,  4'd0,  8'h00, 1'b1, 4'b0010};
        tbl[6] = '{2, OP_SUB, 4'd0,  4'd15, 8'hF1, 1'b0, 4'b0001};
        tbl[7] = '{3, OP_DIV, 4'd15, 4'd15, 8'h01, 1'b0, 4'b0010};
        rr_exp = '{0, 1, 2, 3, 0};
        for (int j = 0; j < N; j++) begin
            r_req[j] = 1'b0;
            r_op[j] = 2'd0;
            r_a[j] = 4'd0;
            r_b[j] = 4'd0;
        end
        apply_reset();
        for (int v = 0; v < 8; v++) begin
            set_req(tbl[v].id, tbl[v].op, tbl[v].a, tbl[v].b);
            cycle();
            chk("vec_granted", last_g, tbl[v].id);
            cycle();
            chk("vec_dp_sel", 32'(dp_sel), 32'(tbl[v].sel));
            cycle();
            cycle();
            chk("vec_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("vec_rsp_id", 32'(bus.rsp_id), tbl[v].id);
            chk("vec_rsp_data", 32'(bus.rsp_data), 32'(tbl[v].data));
            chk("vec_rsp_err", 32'(bus.rsp_err), 32'(tbl[v].err));
            chk("vec_done_cnt", 32'(done_cnt), v + 1);
        end
        apply_reset();
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < N; j++)
                if (!r_req[j]) set_req(j, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
            cycle();
            chk("rr_order", last_g, rr_exp[t]);
        end
        for (int j = 0; j < N; j++) r_req[j] = 1'b0;
        repeat (5) cycle();
        set_req(1, OP_ADD, 4'd5, 4'd6);
        cycle();
        for (int t = 1; t <= 10; t++) begin
            cycle();
            if (t >= 3) chk("iso_busy", 32'(busy), 0);
            if (t >= 2) chk("iso_dp_sel", 32'(dp_sel), 0);
            chk("iso_dp_a", 32'(dp_a), 5);
            chk("iso_dp_b", 32'(dp_b), 6);
        end
        set_req(1, OP_MUL, 4'd3, 4'd4);
        cycle();
        set_req(3, OP_SUB, 4'd8, 4'd2);
        cycle();
        apply_reset();
        set_req(2, OP_ADD, 4'd1, 4'd2);
        set_req(3, OP_ADD, 4'd3, 4'd4);
        cycle();
        chk("rst_rr_first", last_g, 2);
        repeat (6) cycle();
        for (int t = 0; t < 400; t++) begin
            for (int j = 0; j < N; j++) begin
                if (!r_req[j] && $urandom_range(0, 2) == 0)
                    set_req(j, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                            ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15)));
                else if (r_req[j] && $urandom_range(0, 19) == 0)
                    r_req[j] = 1'b0;
            end
            cycle();
        end
        for (int j = 0; j < N; j++) r_req[j] = 1'b0;
        repeat (6) cycle();
        chk("done_sat", 32'(done_cnt), tot > SAT ? SAT : tot);
        chk("drain_busy", 32'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
